// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_prog.
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 11
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_empty;
  logic                  almost_empty;
  logic [DEPTH_WIDTH:0]  water_level;
  logic                  clr_err;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
           water_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO over an inferred simple-dual-port RAM with
// standard or first-word-fall-through read, occupancy count and sticky errors.
module sync_fifo_prog #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 11,
  parameter int ALMOST_FULL_NUM  = 1460,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave fifo
);
  localparam int            LW      = DEPTH_WIDTH + 1;
  localparam int            DEPTH_N = 1 << DEPTH_WIDTH;
  localparam logic [LW-1:0] DEPTH   = LW'(1) << DEPTH_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [DEPTH_N];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]          level;
  logic                   full;
  logic                   empty;
  logic                   wr_ok;
  logic                   rd_ok;
  logic                   rd_adv;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   valid_out;
  logic                   ovf;
  logic                   unf;

  assign full  = (level == DEPTH);
  assign wr_ok = fifo.wr_en && !full;
  assign rd_ok = fifo.rd_en && !empty;

  // RAM write port; contents are never reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wr_ptr] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A rejected request in the same cycle as clr_err keeps its flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (fifo.wr_en && full) begin
        ovf <= 1'b1;
      end else if (fifo.clr_err) begin
        ovf <= 1'b0;
      end
      if (fifo.rd_en && empty) begin
        unf <= 1'b1;
      end else if (fifo.clr_err) begin
        unf <= 1'b0;
      end
    end
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] ram_q_p0;
    logic                  vld_p0;

    assign empty  = (level == '0);
    assign rd_adv = rd_ok;

    // Stage p0: synchronous RAM read
    always_ff @(posedge clk) begin
      if (rd_ok) begin
        ram_q_p0 <= mem[rd_ptr];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p0 <= 1'b0;
      end else begin
        vld_p0 <= rd_ok;
      end
    end

    // Stage p1: output register, holds the last word between reads
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end else begin
        valid_out <= vld_p0;
        if (vld_p0) begin
          data_out <= ram_q_p0;
        end
      end
    end
  end else begin : g_fwft
    logic [LW-1:0] ram_cnt;
    logic          need;
    logic          load_ram;
    logic          bypass;

    // Words still in RAM, excluding the one presented on rd_data
    assign ram_cnt  = level - LW'(valid_out);
    assign need     = !valid_out || rd_ok;
    assign load_ram = need && (ram_cnt != '0);
    // Popping the last word while a write lands: present the new word directly
    assign bypass   = rd_ok && (ram_cnt == '0) && wr_ok;
    assign rd_adv   = load_ram || bypass;
    assign empty    = !valid_out;

    // Stage p0: head register doubles as the RAM read register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end else begin
        if (load_ram) begin
          data_out <= mem[rd_ptr];
        end else if (bypass) begin
          data_out <= fifo.wr_data;
        end
        if (rd_adv) begin
          valid_out <= 1'b1;
        end else if (rd_ok) begin
          valid_out <= 1'b0;
        end
      end
    end
  end

  assign fifo.wr_full      = full;
  assign fifo.almost_full  = (level >= LW'(ALMOST_FULL_NUM));
  assign fifo.rd_data      = data_out;
  assign fifo.rd_valid     = valid_out;
  assign fifo.rd_empty     = empty;
  assign fifo.almost_empty = (level <= LW'(ALMOST_EMPTY_NUM));
  assign fifo.water_level  = level;
  assign fifo.overflow     = ovf;
  assign fifo.underflow    = unf;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: a standard-mode and an FWFT instance share one stimulus
// stream and are checked against queue-based occupancy models.
module tb_sync_fifo_prog;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int NW  = 16;
  localparam int AFN = 12;
  localparam int AEN = 2;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  logic [DW-1:0] exp_f[$];
  exp_t          exp_s[$];
  logic [DW-1:0] last_s = '0;
  bit            h_f = 1'b0;
  bit            ovf_s = 1'b0, unf_s = 1'b0, ovf_f = 1'b0, unf_f = 1'b0;
  int            cyc = 0;
  int            fw_pops = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bs ();
  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bf ();

  assign bs.wr_en   = wr_en;
  assign bs.wr_data = wr_data;
  assign bs.rd_en   = rd_en;
  assign bs.clr_err = clr_err;
  assign bf.wr_en   = wr_en;
  assign bf.wr_data = wr_data;
  assign bf.rd_en   = rd_en;
  assign bf.clr_err = clr_err;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(AFN),
                   .ALMOST_EMPTY_NUM(AEN), .FWFT(0))
    dut_std (.clk(clk), .rst_n(rst_n), .fifo(bs.slave));

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(AFN),
                   .ALMOST_EMPTY_NUM(AEN), .FWFT(1))
    dut_fwft (.clk(clk), .rst_n(rst_n), .fifo(bf.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word list per FIFO, updated from the request rules.
  task automatic model_loop();
    int            lb;
    logic [DW-1:0] d;
    bit            oset, uset;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        q_s.delete(); exp_s.delete(); q_f.delete(); exp_f.delete();
        h_f = 0; ovf_s = 0; unf_s = 0; ovf_f = 0; unf_f = 0; last_s = '0;
      end else begin
        lb   = q_s.size();
        oset = wr_en && (lb == NW);
        uset = rd_en && (lb == 0);
        if (rd_en && lb > 0) begin
          d = q_s.pop_front();
          exp_s.push_back('{d: d, due: cyc + 1});
        end
        if (wr_en && lb < NW) q_s.push_back(wr_data);
        ovf_s = oset ? 1'b1 : (clr_err ? 1'b0 : ovf_s);
        unf_s = uset ? 1'b1 : (clr_err ? 1'b0 : unf_s);
        if (exp_s.size() > 0 && exp_s[0].due == cyc) last_s = exp_s[0].d;

        lb   = q_f.size();
        oset = wr_en && (lb == NW);
        uset = rd_en && !h_f;
        if (rd_en && h_f) void'(q_f.pop_front());
        if (wr_en && lb < NW) begin
          q_f.push_back(wr_data);
          exp_f.push_back(wr_data);
        end
        // A head word is presented once a word has sat in storage for an edge
        h_f   = (q_f.size() > 0) && (h_f || lb > 0);
        ovf_f = oset ? 1'b1 : (clr_err ? 1'b0 : ovf_f);
        unf_f = uset ? 1'b1 : (clr_err ? 1'b0 : unf_f);
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      check("s_level", bs.water_level, q_s.size());
      check("s_full", bs.wr_full, q_s.size() == NW);
      check("s_empty", bs.rd_empty, q_s.size() == 0);
      check("s_afull", bs.almost_full, q_s.size() >= AFN);
      check("s_aempty", bs.almost_empty, q_s.size() <= AEN);
      check("s_ovf", bs.overflow, ovf_s);
      check("s_unf", bs.underflow, unf_s);
      check("s_rd_data", bs.rd_data, last_s);
      if (bs.rd_valid) begin
        if (exp_s.size() == 0 || exp_s[0].due != cyc) begin
          check("s_rd_valid_early", bs.rd_valid, 0);
        end else begin
          e = exp_s.pop_front();
          check("s_rd_word", bs.rd_data, e.d);
        end
      end else if (exp_s.size() > 0 && exp_s[0].due <= cyc) begin
        check("s_rd_valid_missing", bs.rd_valid, 1);
        void'(exp_s.pop_front());
      end

      check("f_level", bf.water_level, q_f.size());
      check("f_full", bf.wr_full, q_f.size() == NW);
      check("f_empty", bf.rd_empty, !h_f);
      check("f_valid", bf.rd_valid, h_f);
      check("f_afull", bf.almost_full, q_f.size() >= AFN);
      check("f_aempty", bf.almost_empty, q_f.size() <= AEN);
      check("f_ovf", bf.overflow, ovf_f);
      check("f_unf", bf.underflow, unf_f);
      if (h_f && exp_f.size() > 0) begin
        check("f_head", bf.rd_data, exp_f[0]);
        if (rd_en) void'(exp_f.pop_front());
      end
      if (rd_en && !bf.rd_empty) fw_pops++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    clr_err = c;
  endtask

  task automatic idle(input int n);
    drive(0, 0, '0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pops0;
    fork
      model_loop();
      monitor_loop();
    join_none

    drive(0, 0, '0, 0);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_s_data", bs.rd_data, 0);
    check("rst_s_valid", bs.rd_valid, 0);
    check("rst_f_data", bf.rd_data, 0);
    check("rst_f_empty", bf.rd_empty, 1);

    // Fill one word at a time through both thresholds, then one extra write
    for (int i = 0; i <= NW; i++) begin
      drive(1, 0, 8'($urandom), 0); step();
      idle(1);
    end
    check("fill_level", bs.water_level, 16);
    check("fill_ovf", bs.overflow, 1);
    drive(0, 0, '0, 1); step();
    drive(1, 1, 8'($urandom), 0); step();
    idle(1);
    check("full_rw_level", bs.water_level, 15);
    check("full_rw_ovf", bs.overflow, 1);
    for (int i = 0; i < NW; i++) begin
      drive(0, 1, '0, 0); step();
      idle(1);
    end
    drive(0, 0, '0, 1); step();
    drive(1, 1, 8'($urandom), 0); step();
    idle(1);
    check("empty_rw_level", bs.water_level, 1);
    check("empty_rw_unf", bs.underflow, 1);
    drive(0, 1, '0, 0); step();
    idle(3);
    drive(0, 1, '0, 1); step();
    idle(1);
    check("clr_vs_unf", bs.underflow, 1);
    drive(0, 0, '0, 1); step();
    idle(1);

    // Back-to-back 0x01..0x10 plus a rejected 17th, then a back-to-back drain
    for (int i = 1; i <= NW + 1; i++) begin
      drive(1, 0, 8'(i), 0); step();
    end
    idle(1);
    for (int i = 0; i < NW; i++) begin
      drive(0, 1, '0, 0); step();
    end
    idle(3);
    check("b2b_empty", bs.rd_empty, 1);
    drive(0, 0, '0, 1); step();
    idle(1);

    // FWFT first-word latency, then a 40-word stream popped every cycle
    drive(1, 0, 8'hA5, 0); step();
    check("fwft_lvl_N", bf.water_level, 1);
    check("fwft_empty_N", bf.rd_empty, 1);
    idle(1);
    check("fwft_empty_N1", bf.rd_empty, 0);
    check("fwft_data_N1", bf.rd_data, 8'hA5);
    pops0 = fw_pops;
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 8'($urandom), 0); step();
    end
    drive(0, 1, '0, 0); step();
    idle(3);
    check("fwft_burst_pops", fw_pops - pops0, 41);

    // Pointer wrap at constant level 8
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'($urandom), 0); step();
    end
    idle(1);
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, 8'($urandom), 0); step();
    end
    idle(1);
    check("wrap_s_level", bs.water_level, 8);
    check("wrap_f_level", bf.water_level, 8);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, '0, 0); step();
    end
    idle(3);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45, 8'($urandom),
            $urandom_range(0, 99) < 4);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, '0, 0); step();
    end
    drive(0, 0, '0, 1); step();
    idle(2);

    // Reset at level 9 with overflow set, requests present in the reset cycle
    for (int i = 0; i <= NW; i++) begin
      drive(1, 0, 8'($urandom), 0); step();
    end
    idle(1);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, '0, 0); step();
    end
    idle(1);
    check("prerst_level", bs.water_level, 9);
    check("prerst_ovf", bf.overflow, 1);
    drive(1, 1, 8'($urandom), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 0, '0, 0);
    check("rst2_s_data", bs.rd_data, 0);
    check("rst2_s_valid", bs.rd_valid, 0);
    check("rst2_s_level", bs.water_level, 0);
    check("rst2_f_data", bf.rd_data, 0);
    check("rst2_f_ovf", bf.overflow, 0);
    check("rst2_f_empty", bf.rd_empty, 1);

    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom), 0);
      step();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised single-clock FIFO replacing the fixed 8-bit/2048-deep vendor FIFO wrappers in the video data path. Data width, depth, almost thresholds and read mode (standard or first-word-fall-through) are compile-time parameters. The block adds a live occupancy count, a read-valid strobe and sticky overflow/underflow error flags. It is behavioural RTL over an inferred simple-dual-port RAM with one-cycle synchronous read, so it carries no IP-generator dependency.

## Interface
Parameters:
- DATA_WIDTH, 8: word width, 1..1152.
- DEPTH_WIDTH, 11: log2 of depth; depth = 2^DEPTH_WIDTH, 4..20.
- ALMOST_FULL_NUM, 1460: almost_full threshold, 1..2^DEPTH_WIDTH.
- ALMOST_EMPTY_NUM, 4: almost_empty threshold, 0..2^DEPTH_WIDTH-1.
- FWFT, 0: 0 = standard read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- wr_full  out  1  FIFO holds 2^DEPTH_WIDTH words.
- almost_full  out  1  water_level >= ALMOST_FULL_NUM.
- rd_en  in  1  read request (pop in FWFT).
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  standard: rd_data valid this cycle; FWFT: equals !rd_empty.
- rd_empty  out  1  no word readable.
- almost_empty  out  1  water_level <= ALMOST_EMPTY_NUM.
- water_level  out  DEPTH_WIDTH+1  words stored (FWFT: includes the presented word).
- clr_err  in  1  clears overflow/underflow.
- overflow  out  1  sticky: write attempted while wr_full.
- underflow  out  1  sticky: read attempted while rd_empty.

## Operation
- Write is accepted when wr_en && !wr_full. Read is accepted when rd_en && !rd_empty. Both flags are sampled before the edge.
- Read and write pointers are DEPTH_WIDTH bits and wrap naturally. water_level is a separate counter: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags derive only from registered state: wr_full = (water_level == 2^DEPTH_WIDTH). Standard mode: rd_empty = (water_level == 0). FWFT: rd_empty = !output-register-valid.
- Simultaneous read and write:
  - Full: read accepted, write rejected, overflow set.
  - Standard mode, empty: write accepted, read rejected, underflow set.
  - FWFT, empty: same as standard mode.
- Standard mode: an accepted read at edge N drives rd_data and rd_valid=1 for one cycle after edge N+1. rd_data holds its last value otherwise.
- FWFT mode: the head word is held on rd_data while rd_empty=0. An accepted rd_en advances to the next word at the same edge. The RAM read address is next-pointer driven, so continuous pops sustain 1 word/clk with no bubbles.
- overflow/underflow set on a rejected request. clr_err clears both; a set event in the same cycle wins over clr_err.
- RAM contents are not reset.

## Timing
- Reset (rst_n=0 at an edge) forces: pointers 0, water_level 0, wr_full 0, almost_full 0, rd_empty 1, almost_empty 1, rd_valid 0, rd_data 0, overflow 0, underflow 0.
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored and set no error flags.
- water_level, wr_full, almost_* update after the accepting edge; 0-cycle flag lag relative to the counter.
- Write-to-read latency, write accepted at edge N into an empty FIFO:
  - Standard: rd_empty=0 after N; earliest rd_en at N+1 gives data after N+2.
  - FWFT: rd_empty=0 and rd_data valid after N+1. water_level=1 already after N.
- A write and a read of the last word at the same edge in FWFT keep rd_empty=0 with no gap, using the new word.
- Full-to-not-full: wr_full drops after the edge accepting a read.

## Test plan
- DEPTH_WIDTH=4, FWFT=0: write 0x01..0x10 back-to-back -> wr_full=1 after 16th edge, water_level=16; 17th write sets overflow=1, level stays 16; read 16 -> 0x01..0x10 in order, rd_valid each cycle, rd_empty=1 at end.
- ALMOST_FULL_NUM=12, ALMOST_EMPTY_NUM=2: fill one word at a time -> almost_empty drops at level 3, almost_full rises at level 12; drain mirrors both.
- Full FIFO, wr_en&&rd_en together for 1 cycle -> level 15, overflow=1, oldest word read; empty FIFO, both together -> level 1, underflow=1.
- FWFT=1: single write 0xA5 at edge N -> rd_data=0xA5, rd_empty=0 after N+1; then 40 words written while rd_en held -> 41 words out in order at 1/clk, no gaps.
- Wrap-around: 100 cycles of concurrent write/read at level 8 -> level constant 8, data order preserved across pointer wrap.
- rst_n low at level 9 with overflow set -> all outputs at reset values next cycle; clr_err in the same cycle as an underflow event -> underflow stays 1.
